// File: rtl/rocket_tm_pkg.sv
// rocket_tm_pkg: definitions shared by the rocket telemetry link master and
// the matching transmitter, so both ends agree on word/frame geometry and timing.
//   tm_state_e    : link sequencing states
//   WORD_W        : bits per telemetry word
//   FRAME_WORDS   : words per frame
//   SYNC_WORD_DEF : value carried by word 0 of every frame
//   *_CYC_DEF     : default load / half-period / inter-frame gap lengths in system clocks
package rocket_tm_pkg;

  localparam int WORD_W       = 10;
  localparam int FRAME_WORDS  = 52;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 10'h3F0;

  localparam int LOAD_CYC_DEF = 5;
  localparam int HALF_CYC_DEF = 5;
  localparam int GAP_CYC_DEF  = 1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLK_HI = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_GAP    = 3'd4
  } tm_state_e;

endpackage

// File: rtl/rocket_tm_gtclk_gen.sv
// rocket_tm_gtclk_gen: link sequencer. Owns the state register, the 16-bit phase
// counter and the 4-bit bit counter, and produces the load strobe and gated clock.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   frame_req    : in IDLE, begin a frame (start or enable)
//   more_words   : the word in flight is not the last of the frame
//   cont         : continuous mode (enable level)
//   gtclk        : registered gated clock (high only in CLK_HI)
//   invload_n    : registered active-low load strobe (low only in LOAD)
//   busy         : registered, high while in LOAD/CLK_HI/CLK_LO
//   idle         : state register is IDLE
//   bit_tick     : last cycle of CLK_HI, sample the serial line now
//   word_tick    : last cycle of the last CLK_LO of a word
//   frame_begin  : this cycle moves into LOAD of word 0
module rocket_tm_gtclk_gen
  import rocket_tm_pkg::*;
#(
  parameter int LOAD_CYC      = LOAD_CYC_DEF,
  parameter int HALF_CYC      = HALF_CYC_DEF,
  parameter int GAP_CYC       = GAP_CYC_DEF,
  parameter int BITS_PER_WORD = WORD_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_req,
  input  logic more_words,
  input  logic cont,
  output logic gtclk,
  output logic invload_n,
  output logic busy,
  output logic idle,
  output logic bit_tick,
  output logic word_tick,
  output logic frame_begin
);

  localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYC - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(BITS_PER_WORD - 1);

  tm_state_e   state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic        gtclk_q, gtclk_d;
  logic        invload_n_q, invload_n_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + 16'd1;
    bit_d       = bit_q;
    bit_tick    = 1'b0;
    word_tick   = 1'b0;
    frame_begin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (frame_req) begin
          state_d     = ST_LOAD;
          frame_begin = 1'b1;
        end
      end
      ST_LOAD: begin
        if (phase_q == LOAD_LAST) begin
          state_d = ST_CLK_HI;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      ST_CLK_HI: begin
        if (phase_q == HALF_LAST) begin
          state_d  = ST_CLK_LO;
          phase_d  = '0;
          bit_tick = 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (bit_q < BIT_LAST) begin
            bit_d   = bit_q + 4'd1;
            state_d = ST_CLK_HI;
          end else begin
            bit_d     = '0;
            word_tick = 1'b1;
            if (more_words)  state_d = ST_LOAD;
            else if (cont)   state_d = ST_GAP;
            else             state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // start is deliberately not looked at here; only enable keeps the link running
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          if (cont) begin
            state_d     = ST_LOAD;
            frame_begin = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        bit_d   = '0;
      end
    endcase

    // Line outputs are decoded from the next state and registered, so the
    // pins toggle exactly with the state register and never glitch.
    gtclk_d     = (state_d == ST_CLK_HI);
    invload_n_d = (state_d != ST_LOAD);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_CLK_HI) || (state_d == ST_CLK_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      gtclk_q     <= 1'b0;
      invload_n_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      gtclk_q     <= gtclk_d;
      invload_n_q <= invload_n_d;
      busy_q      <= busy_d;
    end
  end

  assign gtclk     = gtclk_q;
  assign invload_n = invload_n_q;
  assign busy      = busy_q;
  assign idle      = (state_q == ST_IDLE);

endmodule

// File: rtl/rocket_tm_master.sv
// rocket_tm_master: master end of the rocket telemetry serial link. Drives the
// load strobe and gated clock, samples Cnt_Data MSB-first and assembles 10-bit
// words into 52-word frames, checking word 0 against the sync pattern.
// Ports:
//   Ext_clk_50mhz : system clock
//   Gse_reset_n   : asynchronous active-low reset
//   enable        : level, frames repeat with a GAP_CYC gap while high
//   start         : one-cycle pulse, runs one frame when idle
//   Cnt_Data      : serial data from the transmitter (asynchronous)
//   Cnt_Gtclk     : gated clock to the transmitter
//   Cnt_Invload   : active-low load strobe to the transmitter
//   word_data     : last assembled word
//   word_idx      : index of word_data in its frame
//   word_valid    : one-cycle strobe qualifying word_data/word_idx
//   frame_start   : one-cycle pulse on entry to LOAD of word 0
//   frame_done    : one-cycle pulse together with word_valid of the last word
//   sync_err      : sticky word-0 mismatch flag, cleared when a new run is requested from idle
//   busy          : high while a frame is being clocked
module rocket_tm_master
  import rocket_tm_pkg::*;
#(
  parameter int LOAD_CYC        = LOAD_CYC_DEF,
  parameter int HALF_CYC        = HALF_CYC_DEF,
  parameter int BITS_PER_WORD   = WORD_W,
  parameter int WORDS_PER_FRAME = FRAME_WORDS,
  parameter int GAP_CYC         = GAP_CYC_DEF,
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic              Ext_clk_50mhz,
  input  logic              Gse_reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              Cnt_Data,
  output logic              Cnt_Gtclk,
  output logic              Cnt_Invload,
  output logic [WORD_W-1:0] word_data,
  output logic [5:0]        word_idx,
  output logic              word_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              sync_err,
  output logic              busy
);

  localparam logic [5:0] WORD_LAST = 6'(WORDS_PER_FRAME - 1);

  logic              data_s1_q, data_s1_d;
  logic              data_s2_q, data_s2_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [5:0]        word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic [5:0]        word_idx_q, word_idx_d;
  logic              word_valid_q, word_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q, sync_err_d;
  logic              enable_q, enable_d;

  logic more_words;
  logic idle;
  logic bit_tick;
  logic word_tick;
  logic frame_begin;
  logic run_req_edge;

  assign more_words   = (word_cnt_q < WORD_LAST);
  assign run_req_edge = start | (enable & ~enable_q);

  rocket_tm_gtclk_gen #(
    .LOAD_CYC      (LOAD_CYC),
    .HALF_CYC      (HALF_CYC),
    .GAP_CYC       (GAP_CYC),
    .BITS_PER_WORD (BITS_PER_WORD)
  ) u_gtclk_gen (
    .clk         (Ext_clk_50mhz),
    .rst_n       (Gse_reset_n),
    .frame_req   (start | enable),
    .more_words  (more_words),
    .cont        (enable),
    .gtclk       (Cnt_Gtclk),
    .invload_n   (Cnt_Invload),
    .busy        (busy),
    .idle        (idle),
    .bit_tick    (bit_tick),
    .word_tick   (word_tick),
    .frame_begin (frame_begin)
  );

  always_comb begin
    data_s1_d     = Cnt_Data;
    data_s2_d     = data_s1_q;
    shift_d       = shift_q;
    word_cnt_d    = word_cnt_q;
    word_data_d   = word_data_q;
    word_idx_d    = word_idx_q;
    word_valid_d  = word_tick;
    frame_done_d  = word_tick & ~more_words;
    frame_start_d = frame_begin;
    sync_err_d    = sync_err_q;
    enable_d      = enable;

    // MSB arrives first, so each new bit enters at the LSB
    if (bit_tick) shift_d = {shift_q[WORD_W-2:0], data_s2_q};

    if (frame_begin)                    word_cnt_d = '0;
    else if (word_tick && more_words)   word_cnt_d = word_cnt_q + 6'd1;

    // The last bit was shifted at the end of the preceding CLK_HI, so the
    // shift register already holds the full word here.
    if (word_tick) begin
      word_data_d = shift_q;
      word_idx_d  = word_cnt_q;
      if ((word_cnt_q == '0) && (shift_q != SYNC_WORD)) sync_err_d = 1'b1;
    end

    // Requests while a frame or gap is in progress are ignored, including for the flag
    if (idle && run_req_edge) sync_err_d = 1'b0;
  end

  always_ff @(posedge Ext_clk_50mhz or negedge Gse_reset_n) begin
    if (!Gse_reset_n) begin
      data_s1_q     <= 1'b0;
      data_s2_q     <= 1'b0;
      shift_q       <= '0;
      word_cnt_q    <= '0;
      word_data_q   <= '0;
      word_idx_q    <= '0;
      word_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      enable_q      <= 1'b0;
    end else begin
      data_s1_q     <= data_s1_d;
      data_s2_q     <= data_s2_d;
      shift_q       <= shift_d;
      word_cnt_q    <= word_cnt_d;
      word_data_q   <= word_data_d;
      word_idx_q    <= word_idx_d;
      word_valid_q  <= word_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      sync_err_q    <= sync_err_d;
      enable_q      <= enable_d;
    end
  end

  assign word_data   = word_data_q;
  assign word_idx    = word_idx_q;
  assign word_valid  = word_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_rocket_tm_master.sv
// tb_rocket_tm_master: directed bench for rocket_tm_master with a behavioural
// transmitter (loads a word on the falling load strobe, presents the MSB, and
// advances one bit on each falling gated clock).
`timescale 1ns/1ps
module tb_rocket_tm_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       cnt_data = 1'b0;
  logic       gt;
  logic       inv;
  logic [9:0] word_data;
  logic [5:0] word_idx;
  logic       word_valid;
  logic       frame_start;
  logic       frame_done;
  logic       sync_err;
  logic       busy;

  always #10 clk = ~clk;

  rocket_tm_master dut (
    .Ext_clk_50mhz (clk),
    .Gse_reset_n   (rst_n),
    .enable        (enable),
    .start         (start),
    .Cnt_Data      (cnt_data),
    .Cnt_Gtclk     (gt),
    .Cnt_Invload   (inv),
    .word_data     (word_data),
    .word_idx      (word_idx),
    .word_valid    (word_valid),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .sync_err      (sync_err),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-chosen frame content: sync, index*3, with two bit-order probes
  function automatic logic [9:0] exp_word(input int i);
    logic [9:0] w;
    if (i == 0)      w = 10'h3F0;
    else if (i == 5) w = 10'h201;
    else if (i == 6) w = 10'h001;
    else             w = 10'(i * 3);
    return w;
  endfunction

  // ---------------- transmitter model ----------------
  logic [9:0] tx_words [0:51];

  initial begin : tx_model
    int widx;
    int bidx;
    logic [9:0] cur;
    logic pinv;
    logic pgt;
    widx = 0; bidx = 0; cur = '0; pinv = 1'b1; pgt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        widx = 0; bidx = 0; cnt_data = 1'b0; pinv = 1'b1; pgt = 1'b0;
      end else begin
        if (!inv && pinv) begin
          cur = tx_words[widx];
          widx = (widx + 1) % 52;
          bidx = 9;
          cnt_data = cur[bidx];
        end else if (!gt && pgt && bidx > 0) begin
          bidx--;
          cnt_data = cur[bidx];
        end
        pinv = inv;
        pgt = gt;
      end
    end
  end

  // ---------------- output monitor ----------------
  int cyc = 0;
  int wv_cnt = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;
  int gt_rises = 0;
  int gap_n = 0;
  int fd_cyc = -1;
  logic fd_w51 = 1'b0;
  logic [9:0] rx_data [0:255];
  logic [5:0] rx_idx [0:255];
  int gaps [0:7];

  initial begin : monitor
    logic pg;
    pg = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (word_valid) begin
        if (wv_cnt < 256) begin
          rx_data[wv_cnt] = word_data;
          rx_idx[wv_cnt] = word_idx;
        end
        wv_cnt++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        fd_w51 = word_valid && (word_idx == 6'd51);
      end
      if (frame_start) begin
        if (fd_cyc >= 0 && gap_n < 8) begin
          gaps[gap_n] = cyc - fd_cyc;
          gap_n++;
        end
        fs_cnt++;
      end
      if (gt && !pg) gt_rises++;
      pg = gt;
    end
  end

  task automatic clear_mon();
    wv_cnt = 0; fs_cnt = 0; fd_cnt = 0; gt_rises = 0; gap_n = 0; fd_cyc = -1; fd_w51 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (fd_cnt >= target), 1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int wv_before;
    int fs_before;

    for (int i = 0; i < 52; i++) tx_words[i] = exp_word(i);

    // Reset held with enable high: nothing moves
    rst_n = 1'b0; enable = 1'b1; start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_invload", inv, 1);
    check_eq("rst_gtclk", gt, 0);
    check_eq("rst_word_valid", word_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_start", frame_start, 0);
    check_eq("rst_word_data", word_data, 0);
    check_eq("rst_word_idx", word_idx, 0);
    check_eq("rst_sync_err", sync_err, 0);
    check_eq("rst_no_words", wv_cnt, 0);

    // Release: frame_start after the first clock, load strobe low for 5 clocks
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_frame_start", frame_start, 1);
    check_eq("rel_busy", busy, 1);
    n = 0;
    while (!inv && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq("rel_load_len", n, 5);
    enable = 1'b0;
    wait_done(1, 7000, "tmo_rel_frame");

    // Single frame from a start pulse
    clear_mon();
    pulse_start();
    wait_done(1, 7000, "tmo_single");
    check_eq("single_words", wv_cnt, 52);
    check_eq("single_fs", fs_cnt, 1);
    check_eq("single_fd", fd_cnt, 1);
    check_eq("single_fd_w51", fd_w51, 1);
    check_eq("single_sync_err", sync_err, 0);
    check_eq("single_busy", busy, 0);
    check_eq("single_gt_rises", gt_rises, 520);
    for (int i = 0; i < 52; i++) begin
      check_eq($sformatf("single_idx%0d", i), rx_idx[i], i);
      check_eq($sformatf("single_data%0d", i), rx_data[i], exp_word(i));
    end
    check_eq("bitorder_201", rx_data[5], 10'h201);
    check_eq("bitorder_001", rx_data[6], 10'h001);
    check_eq("word3_val", rx_data[3], 10'd9);
    repeat (100) @(negedge clk);
    check_eq("single_stays_idle", wv_cnt, 52);

    // Sync error: bad word 0 sets a sticky flag, next start clears it
    tx_words[0] = 10'h000;
    clear_mon();
    pulse_start();
    n = 0;
    while (wv_cnt < 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("sync_w0_seen", (wv_cnt >= 1), 1);
    check_eq("sync_set", sync_err, 1);
    check_eq("sync_w0_data", rx_data[0], 10'h000);
    wait_done(1, 7000, "tmo_sync_bad");
    check_eq("sync_sticky", sync_err, 1);
    tx_words[0] = 10'h3F0;
    pulse_start();
    check_eq("sync_cleared", sync_err, 0);
    wait_done(2, 7000, "tmo_sync_good");
    check_eq("sync_good_frame", sync_err, 0);
    check_eq("sync_good_w0", rx_data[52], 10'h3F0);

    // Continuous mode: three frames, enable dropped during word 20 of frame 3
    clear_mon();
    enable = 1'b1;
    n = 0;
    while (wv_cnt < 2 * 52 + 20 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("cont_reach_w20", (wv_cnt >= 124), 1);
    enable = 1'b0;
    check_eq("cont_fs3", fs_cnt, 3);
    wait_done(3, 7000, "tmo_cont");
    check_eq("cont_words", wv_cnt, 156);
    check_eq("cont_fd", fd_cnt, 3);
    check_eq("cont_gap_n", gap_n, 2);
    check_eq("cont_gap1", gaps[0], 1000);
    check_eq("cont_gap2", gaps[1], 1000);
    check_eq("cont_last_idx", rx_idx[155], 51);
    check_eq("cont_busy", busy, 0);
    repeat (1100) @(negedge clk);
    check_eq("cont_stopped", fs_cnt, 3);
    check_eq("cont_no_more_words", wv_cnt, 156);

    // Mid-frame reset during CLK_HI of word 10
    clear_mon();
    pulse_start();
    n = 0;
    while (wv_cnt < 10 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!gt && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("mr_in_clk_hi", gt, 1);
    check_eq("mr_word_idx_before", word_idx, 9);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mr_gtclk", gt, 0);
    check_eq("mr_invload", inv, 1);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_word_valid", word_valid, 0);
    check_eq("mr_word_data", word_data, 0);
    check_eq("mr_word_idx", word_idx, 0);
    check_eq("mr_sync_err", sync_err, 0);
    wv_before = wv_cnt;
    fs_before = fs_cnt;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("mr_idle_words", wv_cnt, wv_before);
    check_eq("mr_idle_fs", fs_cnt, fs_before);
    check_eq("mr_idle_invload", inv, 1);
    check_eq("mr_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rocket_tm_master.md
Name: rocket_tm_master

Overview:
Master end of the rocket telemetry serial link; it is the counterpart of the rocket readout that drives Cnt_Data. It generates the Cnt_Invload load strobe and the Cnt_Gtclk gated clock, samples Cnt_Data MSB-first and assembles 10-bit words. Frames are 52 words long. It serves as the synthesizable GSE/bench master and replaces the hand-timed stimulus loops.

Parameters:
LOAD_CYC, 5, system clocks Cnt_Invload is held low per word (100 ns at 50 MHz)
HALF_CYC, 5, system clocks per Cnt_Gtclk high phase and per low phase
BITS_PER_WORD, 10, gated clocks per word
WORDS_PER_FRAME, 52, words per frame
GAP_CYC, 1000, idle clocks after a frame before the next frame in continuous mode
SYNC_WORD, 10'h3F0, expected value of word 0

Ports:
Ext_clk_50mhz  in  1  system clock
Gse_reset_n  in  1  asynchronous active-low reset
enable  in  1  level; while high, frames repeat back-to-back separated by GAP_CYC
start  in  1  one-cycle pulse; runs a single frame when idle
Cnt_Data  in  1  serial data from the transmitter
Cnt_Gtclk  out  1  gated clock to the transmitter
Cnt_Invload  out  1  active-low load strobe to the transmitter
word_data  out  10  last assembled word
word_idx  out  6  index of word_data within its frame (0..51)
word_valid  out  1  one-cycle strobe, word_data/word_idx valid
frame_start  out  1  one-cycle pulse on entry to LOAD of word 0
frame_done  out  1  one-cycle pulse with word_valid of word 51
sync_err  out  1  sticky; set when word 0 != SYNC_WORD; cleared by start or enable rising edge
busy  out  1  high from LOAD of word 0 to the end of the last CLK_LO

Behaviour:
- Reset values: Cnt_Gtclk=0, Cnt_Invload=1, word_data=0, word_idx=0, word_valid=0, frame_start=0, frame_done=0, sync_err=0, busy=0. All counters and the shift register are 0. The FSM enters IDLE.
- Cnt_Data passes through a 2-flop synchronizer (reset 0). The sampled value is the synchronizer output.
- All outputs are registered. Cnt_Gtclk and Cnt_Invload come directly from the state register, so they are glitch-free.
- FSM states: IDLE, LOAD, CLK_HI, CLK_LO, GAP.
  - IDLE: leaves when start=1 or enable=1. Sets word count to 0, pulses frame_start, goes to LOAD.
  - LOAD: Cnt_Invload=0 and Cnt_Gtclk=0 for LOAD_CYC clocks, then CLK_HI with bit count 0.
  - CLK_HI: Cnt_Invload=1, Cnt_Gtclk=1 for HALF_CYC clocks. In the last clock, shift the sampled Cnt_Data into the LSB of the shift register (MSB arrives first). Then go to CLK_LO.
  - CLK_LO: Cnt_Gtclk=0 for HALF_CYC clocks. At the end:
    - If bit count < BITS_PER_WORD-1: increment bit count, go to CLK_HI.
    - Otherwise: the word is complete, handled as below.
- Word complete, in the cycle that leaves CLK_LO:
  - Register word_data from the shift register; word_idx = word count; word_valid=1 for 1 cycle.
  - If word count==0 and the word != SYNC_WORD, set sync_err.
  - If word count < WORDS_PER_FRAME-1: increment word count, go to LOAD.
  - Otherwise: pulse frame_done. Go to GAP if enable=1, else IDLE.
- GAP: Cnt_Invload=1, Cnt_Gtclk=0 for GAP_CYC clocks.
  - At the end: if enable=1, pulse frame_start and go to LOAD of word 0; else go to IDLE.
  - start is ignored in GAP.
- start or enable rising edge while busy has no effect; a frame is never truncated.
- enable falling mid-frame: the current frame completes, then the FSM goes to IDLE.
- Simultaneous start and enable in IDLE: a single frame_start is issued, and continuous mode applies.
- Word timing: LOAD_CYC + 2*HALF_CYC*BITS_PER_WORD = 105 clocks per word.
- Frame timing: 52*105 = 5460 clocks per frame, plus GAP_CYC.
- Reset assertion mid-frame forces the reset values immediately and discards any partial word.
- Counters: phase counter is 16 bits (covers GAP_CYC), bit counter 4 bits, word counter 6 bits. None of them wrap; each is cleared at state entry.

Decomposition:
- Shared package rocket_tm_pkg holds:
  - the state enum;
  - the constants for word width 10, frame length 52 and SYNC_WORD;
  - the load/half/gap defaults, so the transmitter and this master agree.
- One sub-module, rocket_tm_gtclk_gen: phase counter plus the LOAD/HI/LO sequencing, with bit_tick/word_tick outputs. The word/frame FSM stays in the top of the block.

Test Plan:
- Reset: hold Gse_reset_n=0 with enable=1 -> Cnt_Invload=1, Cnt_Gtclk=0, no word_valid. After release: frame_start on the 1st clock, Cnt_Invload low for exactly 5 clocks.
- Single frame: start pulse with a transmitter model sending SYNC_WORD then words 1..51 equal to index*3.
  - -> 52 word_valid strobes, each word_idx matching its data.
  - -> frame_done together with word 51, sync_err=0, busy low afterwards, exactly 520 Cnt_Gtclk rising edges.
- Bit order: model sends 10'h201 in word 5 -> word_data=10'h201 (MSB first), not 10'h201 reversed (10'h201 is its own reverse in 10 bits, so also send 10'h001 in word 6 -> 10'h001).
- Sync error: word 0 = 10'h000 -> sync_err=1 after word 0 and stays set through the frame; the next start clears it.
- Continuous mode: enable held high for 3 frames -> exactly 1000 idle clocks between frame_done and the next frame_start. Drop enable during word 20 of frame 3 -> frame 3 completes all 52 words, then IDLE.
- Mid-frame reset: assert Gse_reset_n low during CLK_HI of word 10 -> outputs return to reset values in the same cycle. After release with enable=0 and no start -> remains IDLE, no word_valid.
